udi_thr_evt: RTL

UDI_THR_EVT -- requirements
Module: udi_thr_evt

---
 rtl/udi_thr_evt.sv | 120 ++++++++++++
 1 files changed

// File: rtl/udi_thr_evt.sv
// UDI threshold event detector: counts consecutive above-threshold compare results
// and raises a level event request, with acknowledge and a configurable hold-off.
module udi_thr_evt #(
    parameter int CNT_W  = 8,
    parameter int TOT_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic              gclk,
    input  logic              greset_n,
    input  logic              res_valid_m,
    input  logic              res_cmp_m,
    input  logic              kill_m,
    input  logic              cfg_wr,
    input  logic [CNT_W-1:0]  cfg_trig,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic              evt_ack,
    output logic              evt_irq,
    output logic [CNT_W-1:0]  evt_run,
    output logic [TOT_W-1:0]  evt_total,
    output logic [1:0]        evt_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        FIRED = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  trig_r, trig_nxt, trig_eff, run_nxt;
    logic [HOLD_W-1:0] hold_r, hold_nxt, hold_cnt, hold_cnt_nxt;
    logic [TOT_W-1:0]  total_nxt;
    logic              irq_nxt;
    logic              smp_acc;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TOT_W-1:0] sat_inc_tot(input logic [TOT_W-1:0] v);
        return (&v) ? v : v + TOT_W'(1);
    endfunction

    assign smp_acc   = res_valid_m & ~kill_m;
    assign trig_eff  = (trig_r == '0) ? CNT_W'(1) : trig_r;
    assign evt_state = state;

    always_comb begin
        state_nxt    = state;
        trig_nxt     = trig_r;
        hold_nxt     = hold_r;
        hold_cnt_nxt = hold_cnt;
        run_nxt      = evt_run;
        total_nxt    = evt_total;
        irq_nxt      = evt_irq;
        if (cfg_wr) begin
            // configuration wins over acknowledge and drops any coincident sample
            trig_nxt     = cfg_trig;
            hold_nxt     = cfg_hold;
            run_nxt      = '0;
            hold_cnt_nxt = '0;
            irq_nxt      = 1'b0;
            state_nxt    = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    // run reached the trigger on the previous edge: fire now
                    if (evt_run == trig_eff) begin
                        state_nxt = FIRED;
                        irq_nxt   = 1'b1;
                        run_nxt   = '0;
                        total_nxt = sat_inc_tot(evt_total);
                    end else if (smp_acc) begin
                        run_nxt = res_cmp_m ? sat_inc_cnt(evt_run) : '0;
                    end
                end
                FIRED: begin
                    if (evt_ack) begin
                        irq_nxt = 1'b0;
                        if (hold_r == '0) begin
                            state_nxt = ARMED;
                        end else begin
                            state_nxt    = HOLD;
                            hold_cnt_nxt = hold_r;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt_nxt = (hold_cnt == '0) ? '0 : hold_cnt - HOLD_W'(1);
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state_nxt = ARMED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            state     <= IDLE;
            trig_r    <= CNT_W'(1);
            hold_r    <= '0;
            hold_cnt  <= '0;
            evt_run   <= '0;
            evt_total <= '0;
            evt_irq   <= 1'b0;
        end else begin
            state     <= state_nxt;
            trig_r    <= trig_nxt;
            hold_r    <= hold_nxt;
            hold_cnt  <= hold_cnt_nxt;
            evt_run   <= run_nxt;
            evt_total <= total_nxt;
            evt_irq   <= irq_nxt;
        end
    end

endmodule
